// File: rtl/decoder_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_seq_pkg
// Shared definitions for the ITABLE instruction sequencers.
//   seq_state_e     : M-cycle level state of a direct-address transfer
//   ITABLE_XPT_BASE : XPT value of the first T-state after the opcode fetch
//   seq_last_xpt()  : XPT value of the final T-state of an undelayed sequence
// -----------------------------------------------------------------------------
package decoder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OPL  = 2'd1,
      ST_OPH  = 2'd2,
      ST_DATA = 2'd3
   } seq_state_e;

   localparam int unsigned ITABLE_XPT_BASE = 3;

   // Two operand M-cycles plus one M-cycle per data byte.
   function automatic longint unsigned seq_last_xpt(input int unsigned base,
                                                    input int unsigned bytes,
                                                    input int unsigned ts);
      return longint'(base) + longint'(2 + bytes) * longint'(ts) - 1;
   endfunction

endpackage

// File: rtl/seq_tstate_counter.sv
// -----------------------------------------------------------------------------
// seq_tstate_counter
// T-state counter for non-opcode M-cycles. Counts 0..TS_PER_M-1 while run is
// high and wraps; holds at T-state 1 while wait_n is low. Shared by the
// ITABLE sequencers.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high
//   run      : registered "sequence active"; counter is cleared when low
//   wait_n   : active-low memory wait, only honoured at T-state 1
//   mphase   : one-hot T-state, all zero when not running
//   t_is_one : current T-state is index 1 (bus strobe slot)
//   last_t   : current T-state is the last one of the M-cycle
//   stall    : T-state 1 is being stretched this cycle
// -----------------------------------------------------------------------------
module seq_tstate_counter #(
   parameter int unsigned TS_PER_M = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                wait_n,
   output logic [TS_PER_M-1:0] mphase,
   output logic                t_is_one,
   output logic                last_t,
   output logic                stall
);

   localparam int unsigned    T_W    = $clog2(TS_PER_M);
   localparam logic [T_W-1:0] T_ONE  = T_W'(1);
   localparam logic [T_W-1:0] T_LAST = T_W'(TS_PER_M - 1);

   logic [T_W-1:0] t_q;
   logic [T_W-1:0] t_d;

   // t_is_one and last_t come from registers only; stall is the one input path
   // and it never coincides with last_t because TS_PER_M >= 3.
   assign t_is_one = run && (t_q == T_ONE);
   assign last_t   = run && (t_q == T_LAST);
   assign stall    = t_is_one && !wait_n;

   always_comb begin
      mphase = '0;
      if (run) begin
         mphase = TS_PER_M'(1) << t_q;
      end
   end

   always_comb begin
      t_d = t_q;
      if (!run) begin
         t_d = '0;
      end else if (stall) begin
         t_d = t_q;
      end else if (last_t) begin
         t_d = '0;
      end else begin
         t_d = t_q + T_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         t_q <= '0;
      end else begin
         t_q <= t_d;
      end
   end

endmodule

// File: rtl/ldnn_transfer_sequencer.sv
// -----------------------------------------------------------------------------
// ldnn_transfer_sequencer
// Sequences LD (nn),rr (store) and LD rr,(nn) (load) with DATA_BYTES data
// bytes: operand low fetch, operand high fetch, then one M-cycle per byte.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; xpt parked at XPT_BASE
//   OPL     | fetch operand low byte from PC, latch into temp, bump PC
//   OPH     | fetch operand high byte from PC, latch into temp, bump PC
//   DATA    | move byte byte_index at temp nn + byte_index; done on last
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, is_load  : begin pulse from decoder, mode sampled with start
//   wait_n          : active-low memory wait (honoured at T-state 1 only)
//   busy, xpt       : sequence active, absolute T-state count
//   mphase          : one-hot T-state within the M-cycle
//   m_opl/m_oph/m_data, byte_index : current M-cycle and data byte
//   addr_sel_tmp    : address from temp (1) or PC (0)
//   mem_rd, mem_wr  : bus strobes
//   latch_opl/latch_oph/latch_data, pc_inc : datapath enables
//   done            : one-cycle completion strobe in the final T-state
// -----------------------------------------------------------------------------
module ldnn_transfer_sequencer
   import decoder_seq_pkg::*;
#(
   parameter int unsigned DATA_BYTES = 2,
   parameter int unsigned TS_PER_M   = 3,
   parameter int unsigned XPT_BASE   = ITABLE_XPT_BASE,
   parameter int unsigned XPT_W      = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                is_load,
   input  logic                wait_n,
   output logic                busy,
   output logic [XPT_W-1:0]    xpt,
   output logic [TS_PER_M-1:0] mphase,
   output logic                m_opl,
   output logic                m_oph,
   output logic                m_data,
   output logic [1:0]          byte_index,
   output logic                addr_sel_tmp,
   output logic                mem_rd,
   output logic                mem_wr,
   output logic                latch_opl,
   output logic                latch_oph,
   output logic                latch_data,
   output logic                pc_inc,
   output logic                done
);

   if (DATA_BYTES < 1 || DATA_BYTES > 4) begin : g_bad_data_bytes
      $fatal(1, "ldnn_transfer_sequencer: DATA_BYTES must be 1..4");
   end
   if (TS_PER_M < 3 || TS_PER_M > 6) begin : g_bad_ts_per_m
      $fatal(1, "ldnn_transfer_sequencer: TS_PER_M must be 3..6");
   end
   if (XPT_W < 1 || XPT_W > 32) begin : g_bad_xpt_w
      $fatal(1, "ldnn_transfer_sequencer: XPT_W must be 1..32");
   end else if (seq_last_xpt(XPT_BASE, DATA_BYTES, TS_PER_M) >
                ((64'd1 << XPT_W) - 64'd1)) begin : g_xpt_too_narrow
      $fatal(1, "ldnn_transfer_sequencer: XPT_W too narrow for final xpt");
   end

   localparam logic [1:0]       BYTE_LAST = 2'(DATA_BYTES - 1);
   localparam logic [XPT_W-1:0] XPT_IDLE  = XPT_W'(XPT_BASE);
   localparam logic [XPT_W-1:0] XPT_ONE   = XPT_W'(1);

   seq_state_e       state_q, state_d;
   logic [1:0]       byte_q, byte_d;
   logic             mode_q, mode_d;
   logic [XPT_W-1:0] xpt_q, xpt_d;

   logic run;
   logic t_is_one;
   logic last_t;
   logic stall;

   assign run = (state_q != ST_IDLE);

   seq_tstate_counter #(
      .TS_PER_M (TS_PER_M)
   ) u_tstate (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .wait_n   (wait_n),
      .mphase   (mphase),
      .t_is_one (t_is_one),
      .last_t   (last_t),
      .stall    (stall)
   );

   // Next-state logic
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      mode_d  = mode_q;
      xpt_d   = xpt_q;

      unique case (state_q)
         ST_IDLE: begin
            byte_d = '0;
            if (start) begin
               state_d = ST_OPL;
               mode_d  = is_load;
            end
         end
         ST_OPL: begin
            if (last_t) begin
               state_d = ST_OPH;
            end
         end
         ST_OPH: begin
            if (last_t) begin
               state_d = ST_DATA;
               byte_d  = '0;
            end
         end
         ST_DATA: begin
            if (last_t) begin
               if (byte_q == BYTE_LAST) begin
                  state_d = ST_IDLE;
                  byte_d  = '0;
               end else begin
                  byte_d = byte_q + 2'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            byte_d  = '0;
         end
      endcase

      // xpt parks at the base while idle and on the way back to idle, so the
      // first T-state of the next sequence already shows XPT_BASE.
      if (!run || state_d == ST_IDLE) begin
         xpt_d = XPT_IDLE;
      end else if (!stall) begin
         xpt_d = xpt_q + XPT_ONE;
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      m_opl        = 1'b0;
      m_oph        = 1'b0;
      m_data       = 1'b0;
      byte_index   = '0;
      addr_sel_tmp = 1'b0;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      latch_opl    = 1'b0;
      latch_oph    = 1'b0;
      latch_data   = 1'b0;
      pc_inc       = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         ST_OPL: begin
            m_opl     = 1'b1;
            mem_rd    = t_is_one;
            latch_opl = last_t;
            pc_inc    = last_t;
         end
         ST_OPH: begin
            m_oph     = 1'b1;
            mem_rd    = t_is_one;
            latch_oph = last_t;
            pc_inc    = last_t;
         end
         ST_DATA: begin
            m_data       = 1'b1;
            byte_index   = byte_q;
            addr_sel_tmp = 1'b1;
            if (mode_q) begin
               mem_rd     = t_is_one;
               latch_data = last_t;
            end else begin
               mem_wr = t_is_one;
            end
            done = last_t && (byte_q == BYTE_LAST);
         end
         default: begin
         end
      endcase
   end

   assign busy = run;
   assign xpt  = xpt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         byte_q  <= '0;
         mode_q  <= 1'b0;
         xpt_q   <= XPT_IDLE;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         mode_q  <= mode_d;
         xpt_q   <= xpt_d;
      end
   end

endmodule
